// File: rtl/sdram_wb_arb_pkg.sv
//============================================================================
// Module      : sdram_wb_arb_pkg
// Description : Shared types and constants for the two-master SDRAM
//               Wishbone arbiter.
// Revision    : 1.0
//============================================================================
`default_nettype none

package sdram_wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    localparam logic [1:0] c_GRANT_NONE = 2'b00;
    localparam logic [1:0] c_GRANT_M0   = 2'b01;
    localparam logic [1:0] c_GRANT_M1   = 2'b10;

    localparam int c_TIMEOUT_DEFAULT = 255;

endpackage

`default_nettype wire

// File: rtl/sdram_wb_arb_if.sv
//============================================================================
// Module      : sdram_wb_arb_if
// Description : Bundle of both master Wishbone links, the SDRAM-side
//               Wishbone link and the grant vector.
// Revision    : 1.0
//============================================================================
`default_nettype none

interface sdram_wb_arb_if #(
    parameter int dw = 32,
    parameter int aw = 26
);
    logic            m0_cyc_i, m0_stb_i, m0_we_i;
    logic [aw-1:0]   m0_addr_i;
    logic [dw-1:0]   m0_dat_i;
    logic [dw/8-1:0] m0_sel_i;
    logic [2:0]      m0_cti_i;
    logic            m0_ack_o, m0_err_o;
    logic [dw-1:0]   m0_dat_o;

    logic            m1_cyc_i, m1_stb_i, m1_we_i;
    logic [aw-1:0]   m1_addr_i;
    logic [dw-1:0]   m1_dat_i;
    logic [dw/8-1:0] m1_sel_i;
    logic [2:0]      m1_cti_i;
    logic            m1_ack_o, m1_err_o;
    logic [dw-1:0]   m1_dat_o;

    logic            wb_cyc_o, wb_stb_o, wb_we_o;
    logic [aw-1:0]   wb_addr_o;
    logic [dw-1:0]   wb_dat_o;
    logic [dw/8-1:0] wb_sel_o;
    logic [2:0]      wb_cti_o;
    logic            wb_ack_i;
    logic [dw-1:0]   wb_dat_i;

    logic [1:0]      grant_o;

    // Arbiter side of the bundle
    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_dat_i, m0_sel_i, m0_cti_i,
        output m0_ack_o, m0_err_o, m0_dat_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_dat_i, m1_sel_i, m1_cti_i,
        output m1_ack_o, m1_err_o, m1_dat_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        input  wb_ack_i, wb_dat_i,
        output grant_o
    );

    // Environment side: the two masters plus the SDRAM controller
    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_dat_i, m0_sel_i, m0_cti_i,
        input  m0_ack_o, m0_err_o, m0_dat_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_dat_i, m1_sel_i, m1_cti_i,
        input  m1_ack_o, m1_err_o, m1_dat_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        output wb_ack_i, wb_dat_i,
        input  grant_o
    );

endinterface

`default_nettype wire

// File: rtl/sdram_wb_arb_wdt.sv
//============================================================================
// Module      : sdram_wb_arb_wdt
// Description : Ack watchdog: counts strobed cycles without ack and flags
//               expiry when the count reaches TIMEOUT.
// Revision    : 1.0
//============================================================================
`default_nettype none

module sdram_wb_arb_wdt
    import sdram_wb_arb_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic sys_clk,
    input  logic RESET,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);

    localparam int c_CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [c_CW-1:0] r_cnt;

    assign o_expire = (r_cnt == c_CW'(TIMEOUT));

    // Saturates at TIMEOUT so the expiry flag cannot wrap away
    always_ff @(posedge sys_clk or posedge RESET) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_expire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sdram_wb_arb.sv
//============================================================================
// Module      : sdram_wb_arb
// Description : Two-master round-robin Wishbone arbiter in front of an SDRAM
//               controller; the bus stays locked while the owner holds cyc.
//               Optional ack timeout enabled by SDRAM_WB_ARB_TIMEOUT_EN.
// Revision    : 1.0
//============================================================================
`default_nettype none

module sdram_wb_arb
    import sdram_wb_arb_pkg::*;
#(
    parameter int dw      = 32,
    parameter int aw      = 26,
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic          sys_clk,
    input  logic          RESET,
    sdram_wb_arb_if.slave bus
);

    state_t r_state, w_state_nxt;
    logic   r_last;             // master served most recently
    logic   w_req0, w_req1;
    logic   w_expire;
    logic   w_ack0, w_ack1, w_err0, w_err1;

    logic            w_cyc, w_stb, w_we;
    logic [aw-1:0]   w_addr;
    logic [dw-1:0]   w_dat;
    logic [dw/8-1:0] w_sel;
    logic [2:0]      w_cti;
    logic [1:0]      w_grant;

    logic w_unused_params;
    assign w_unused_params = (TIMEOUT > 0);

    assign w_req0 = bus.m0_cyc_i & bus.m0_stb_i;
    assign w_req1 = bus.m1_cyc_i & bus.m1_stb_i;

    always_ff @(posedge sys_clk or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == ST_OWN0 && r_state != ST_OWN0) begin
                r_last <= 1'b0;
            end else if (w_state_nxt == ST_OWN1 && r_state != ST_OWN1) begin
                r_last <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 && w_req1) begin
                    w_state_nxt = r_last ? ST_OWN0 : ST_OWN1;
                end else if (w_req0) begin
                    w_state_nxt = ST_OWN0;
                end else if (w_req1) begin
                    w_state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (w_expire) begin
                    w_state_nxt = ST_ABORT;
                end else if (!bus.m0_cyc_i) begin
                    if (w_req1)      w_state_nxt = ST_OWN1;
                    else if (w_req0) w_state_nxt = ST_OWN0;
                    else             w_state_nxt = ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (w_expire) begin
                    w_state_nxt = ST_ABORT;
                end else if (!bus.m1_cyc_i) begin
                    if (w_req0)      w_state_nxt = ST_OWN0;
                    else if (w_req1) w_state_nxt = ST_OWN1;
                    else             w_state_nxt = ST_IDLE;
                end
            end
            ST_ABORT: begin
                // r_last still names the aborted master
                if (!(r_last ? bus.m1_cyc_i : bus.m0_cyc_i)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cyc   = 1'b0;
        w_stb   = 1'b0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_dat   = '0;
        w_sel   = '0;
        w_cti   = '0;
        w_grant = c_GRANT_NONE;
        w_ack0  = 1'b0;
        w_ack1  = 1'b0;
        w_err0  = 1'b0;
        w_err1  = 1'b0;
        case (r_state)
            ST_OWN0: begin
                w_cyc   = bus.m0_cyc_i;
                w_stb   = bus.m0_stb_i;
                w_we    = bus.m0_we_i;
                w_addr  = bus.m0_addr_i;
                w_dat   = bus.m0_dat_i;
                w_sel   = bus.m0_sel_i;
                w_cti   = bus.m0_cti_i;
                w_grant = c_GRANT_M0;
                w_ack0  = bus.wb_ack_i & ~w_expire;
                w_err0  = w_expire;
            end
            ST_OWN1: begin
                w_cyc   = bus.m1_cyc_i;
                w_stb   = bus.m1_stb_i;
                w_we    = bus.m1_we_i;
                w_addr  = bus.m1_addr_i;
                w_dat   = bus.m1_dat_i;
                w_sel   = bus.m1_sel_i;
                w_cti   = bus.m1_cti_i;
                w_grant = c_GRANT_M1;
                w_ack1  = bus.wb_ack_i & ~w_expire;
                w_err1  = w_expire;
            end
            default: ;
        endcase
    end

`ifdef SDRAM_WB_ARB_TIMEOUT_EN
    logic w_wdt_clr, w_wdt_inc;

    // Any state change covers the clear-on-entry into an owner state
    assign w_wdt_clr = bus.wb_ack_i | (w_state_nxt != r_state);
    assign w_wdt_inc = (r_state == ST_OWN0 || r_state == ST_OWN1) & w_stb & ~bus.wb_ack_i;

    sdram_wb_arb_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .sys_clk  (sys_clk),
        .RESET    (RESET),
        .i_clr    (w_wdt_clr),
        .i_inc    (w_wdt_inc),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    assign bus.wb_cyc_o  = w_cyc;
    assign bus.wb_stb_o  = w_stb;
    assign bus.wb_we_o   = w_we;
    assign bus.wb_addr_o = w_addr;
    assign bus.wb_dat_o  = w_dat;
    assign bus.wb_sel_o  = w_sel;
    assign bus.wb_cti_o  = w_cti;
    assign bus.grant_o   = w_grant;

    assign bus.m0_ack_o  = w_ack0;
    assign bus.m1_ack_o  = w_ack1;
    assign bus.m0_err_o  = w_err0;
    assign bus.m1_err_o  = w_err1;
    assign bus.m0_dat_o  = w_ack0 ? bus.wb_dat_i : '0;
    assign bus.m1_dat_o  = w_ack1 ? bus.wb_dat_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_sdram_wb_arb.sv
//============================================================================
// Module      : tb_sdram_wb_arb
// Description : Self-checking bench for sdram_wb_arb: directed table,
//               hand-written corner sequences and a randomized run.
// Revision    : 1.0
//============================================================================
`default_nettype none

module tb_sdram_wb_arb;

    localparam int DW = 32;
    localparam int AW = 26;
    localparam int TO = 8;
    localparam logic [DW-1:0] RD = 32'h12345678;
`ifdef SDRAM_WB_ARB_TIMEOUT_EN
    localparam bit TOEN = 1'b1;
`else
    localparam bit TOEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_wb_arb_if #(.dw(DW), .aw(AW)) bus ();

    sdram_wb_arb #(.dw(DW), .aw(AW), .TIMEOUT(TO)) dut (
        .sys_clk (clk),
        .RESET   (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic [1:0]    grant;
        logic          cyc, stb, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
        logic [3:0]    sel;
        logic [2:0]    cti;
        logic          a0, a1, e0, e1;
        logic [DW-1:0] d0, d1;
    } obs_t;

    typedef struct {
        logic       rst, c0, s0, w0, c1, s1, ack;
        logic [1:0] grant;
        logic       wcyc, wstb, a0, a1;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: mode 0 idle, 1 owned, 2 aborted
    int m_mode, m_own, m_last, m_cnt;

    function automatic obs_t actual();
        obs_t a;
        a.grant = bus.grant_o;   a.cyc = bus.wb_cyc_o;  a.stb = bus.wb_stb_o;
        a.we    = bus.wb_we_o;   a.addr = bus.wb_addr_o; a.dat = bus.wb_dat_o;
        a.sel   = bus.wb_sel_o;  a.cti = bus.wb_cti_o;
        a.a0 = bus.m0_ack_o; a.a1 = bus.m1_ack_o; a.e0 = bus.m0_err_o; a.e1 = bus.m1_err_o;
        a.d0 = bus.m0_dat_o; a.d1 = bus.m1_dat_o;
        return a;
    endfunction

    function automatic obs_t expect_for(int owner, logic ackb, logic errb);
        obs_t e = '0;
        if (owner == 0) begin
            e.grant = 2'b01; e.cyc = bus.m0_cyc_i; e.stb = bus.m0_stb_i; e.we = bus.m0_we_i;
            e.addr = bus.m0_addr_i; e.dat = bus.m0_dat_i; e.sel = bus.m0_sel_i; e.cti = bus.m0_cti_i;
            e.a0 = ackb; e.e0 = errb;
        end else if (owner == 1) begin
            e.grant = 2'b10; e.cyc = bus.m1_cyc_i; e.stb = bus.m1_stb_i; e.we = bus.m1_we_i;
            e.addr = bus.m1_addr_i; e.dat = bus.m1_dat_i; e.sel = bus.m1_sel_i; e.cti = bus.m1_cti_i;
            e.a1 = ackb; e.e1 = errb;
        end
        e.d0 = e.a0 ? bus.wb_dat_i : '0;
        e.d1 = e.a1 ? bus.wb_dat_i : '0;
        return e;
    endfunction

    task automatic check_obs(input string name, input obs_t e);
        obs_t a;
        a = actual();
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got grant=%b cyc=%b stb=%b we=%b addr=%h dat=%h cti=%b ack10=%b%b err10=%b%b d0=%h d1=%h | want grant=%b cyc=%b stb=%b we=%b addr=%h dat=%h cti=%b ack10=%b%b err10=%b%b d0=%h d1=%h",
                     name, $time, a.grant, a.cyc, a.stb, a.we, a.addr, a.dat, a.cti, a.a1, a.a0, a.e1, a.e0, a.d0, a.d1,
                     e.grant, e.cyc, e.stb, e.we, e.addr, e.dat, e.cti, e.a1, e.a0, e.e1, e.e0, e.d0, e.d1);
        end
    endtask

    task automatic set_m(input int n, input logic c, input logic s, input logic w,
                         input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [2:0] cti);
        if (n == 0) begin
            bus.m0_cyc_i = c; bus.m0_stb_i = s; bus.m0_we_i = w;
            bus.m0_addr_i = ad; bus.m0_dat_i = d; bus.m0_sel_i = 4'hF; bus.m0_cti_i = cti;
        end else begin
            bus.m1_cyc_i = c; bus.m1_stb_i = s; bus.m1_we_i = w;
            bus.m1_addr_i = ad; bus.m1_dat_i = d; bus.m1_sel_i = 4'hF; bus.m1_cti_i = cti;
        end
    endtask

    // Advance the reference model across one clock edge using the held inputs
    task automatic model_step(input logic expire);
        logic [1:0] cy, rq, sb;
        int o;
        cy = {bus.m1_cyc_i, bus.m0_cyc_i};
        sb = {bus.m1_stb_i, bus.m0_stb_i};
        rq = cy & sb;
        case (m_mode)
            0: begin
                o = -1;
                if (rq == 2'b11) o = (m_last == 0) ? 1 : 0;
                else if (rq[0])  o = 0;
                else if (rq[1])  o = 1;
                if (o >= 0) begin m_mode = 1; m_own = o; m_last = o; m_cnt = 0; end
            end
            1: begin
                if (expire) begin
                    m_mode = 2; m_cnt = 0;
                end else if (cy[m_own]) begin
                    if (bus.wb_ack_i) m_cnt = 0;
                    else if (sb[m_own]) m_cnt++;
                end else begin
                    o = 1 - m_own;
                    if (rq[o]) begin m_own = o; m_last = o; m_cnt = 0; end
                    else if (!rq[m_own]) begin m_mode = 0; m_cnt = 0; end
                end
            end
            default: begin
                if (!cy[m_own]) m_mode = 0;
                m_cnt = 0;
            end
        endcase
    endtask

    vec_t vt[17];
    obs_t e;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_word;

    initial begin
        int owner;
        logic exp_m, c0, c1;

        set_m(0, 0, 0, 0, '0, '0, 3'b000);
        set_m(1, 0, 0, 0, '0, '0, 3'b000);
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = RD;

        //        rst c0 s0 w0 c1 s1 ack  grant  wcyc wstb a0 a1
        vt[0]  = '{1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0};
        vt[2]  = '{0, 1, 1, 1, 0, 0, 1, 2'b01, 1, 1, 1, 0};
        vt[3]  = '{0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0};
        vt[4]  = '{0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0};
        vt[5]  = '{1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0};
        vt[6]  = '{0, 1, 1, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0};
        vt[7]  = '{0, 1, 1, 1, 1, 1, 1, 2'b01, 1, 1, 1, 0};
        vt[8]  = '{0, 0, 0, 0, 1, 1, 0, 2'b01, 0, 0, 0, 0};
        vt[9]  = '{0, 1, 1, 1, 1, 1, 1, 2'b10, 1, 1, 0, 1};
        vt[10] = '{0, 1, 1, 1, 1, 1, 1, 2'b10, 1, 1, 0, 1};
        vt[11] = '{0, 1, 1, 1, 1, 1, 1, 2'b10, 1, 1, 0, 1};
        vt[12] = '{0, 1, 1, 1, 1, 1, 1, 2'b10, 1, 1, 0, 1};
        vt[13] = '{0, 1, 1, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0};
        vt[14] = '{0, 1, 1, 1, 0, 0, 1, 2'b01, 1, 1, 1, 0};
        vt[15] = '{0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0};
        vt[16] = '{0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0};

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            rst = vt[i].rst;
            set_m(0, vt[i].c0, vt[i].s0, vt[i].w0, 26'h010, 32'hDEADBEEF, 3'b000);
            set_m(1, vt[i].c1, vt[i].s1, 1'b0, 26'h020, 32'h0BADF00D, (i == 12) ? 3'b111 : 3'b010);
            bus.wb_ack_i = vt[i].ack;
            bus.wb_dat_i = RD;
            #1;
            owner = (vt[i].grant == 2'b01) ? 0 : (vt[i].grant == 2'b10) ? 1 : -1;
            e = expect_for(owner, 1'b0, 1'b0);
            e.cyc = vt[i].wcyc; e.stb = vt[i].wstb; e.a0 = vt[i].a0; e.a1 = vt[i].a1;
            e.d0 = e.a0 ? RD : '0;
            e.d1 = e.a1 ? RD : '0;
            check_obs($sformatf("table[%0d]", i), e);
        end

        // m0 writes 0x12345678 at 0x020, m1 reads it back through a one-word slave
        @(negedge clk);
        bus.wb_ack_i = 1'b0;
        set_m(0, 1, 1, 1, 26'h020, 32'h12345678, 3'b000);
        @(negedge clk);
        bus.wb_ack_i = 1'b1;
        #1;
        check_obs("wr_own0", expect_for(0, 1'b1, 1'b0));
        mem_addr = bus.wb_addr_o;
        mem_word = bus.wb_dat_o;
        @(negedge clk);
        bus.wb_ack_i = 1'b0;
        set_m(0, 0, 0, 0, '0, '0, 3'b000);
        @(negedge clk);
        set_m(1, 1, 1, 0, 26'h020, '0, 3'b000);
        @(negedge clk);
        bus.wb_dat_i = (bus.wb_addr_o == mem_addr) ? mem_word : '0;
        bus.wb_ack_i = 1'b1;
        #1;
        n_vec++;
        if (bus.m1_dat_o !== 32'h12345678 || bus.m1_ack_o !== 1'b1 || bus.m0_ack_o !== 1'b0) begin
            n_bad++;
            $display("FAIL readback: got m1_dat=%h m1_ack=%b m0_ack=%b, want 12345678 1 0",
                     bus.m1_dat_o, bus.m1_ack_o, bus.m0_ack_o);
        end
        @(negedge clk);
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = RD;
        set_m(1, 0, 0, 0, '0, '0, 3'b000);

        // Asynchronous reset in the middle of an m0 transfer
        @(negedge clk);
        set_m(0, 1, 1, 1, 26'h040, 32'hCAFE0001, 3'b000);
        @(negedge clk);
        #1;
        check_obs("pre_reset_own0", expect_for(0, 1'b0, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        check_obs("reset_async", '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_obs("after_reset_idle", expect_for(-1, 1'b0, 1'b0));
        @(negedge clk);
        #1;
        check_obs("after_reset_regrant", expect_for(0, 1'b0, 1'b0));
        @(negedge clk);
        set_m(0, 0, 0, 0, '0, '0, 3'b000);
        @(negedge clk);

`ifdef SDRAM_WB_ARB_TIMEOUT_EN
        // Slave never acks: m0 times out, bus parks in abort, then m1 is served
        @(negedge clk);
        set_m(0, 1, 1, 0, 26'h080, '0, 3'b000);
        #1;
        check_obs("to_idle", expect_for(-1, 1'b0, 1'b0));
        for (int k = 0; k <= TO; k++) begin
            @(negedge clk);
            if (k == 2) set_m(1, 1, 1, 0, 26'h0C0, '0, 3'b000);
            #1;
            check_obs($sformatf("to_wait[%0d]", k), expect_for(0, 1'b0, (k == TO)));
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check_obs($sformatf("to_abort[%0d]", k), expect_for(-1, 1'b0, 1'b0));
        end
        @(negedge clk);
        set_m(0, 0, 0, 0, '0, '0, 3'b000);
        #1;
        check_obs("to_abort_release", expect_for(-1, 1'b0, 1'b0));
        @(negedge clk);
        #1;
        check_obs("to_idle_after", expect_for(-1, 1'b0, 1'b0));
        @(negedge clk);
        #1;
        check_obs("to_m1_granted", expect_for(1, 1'b0, 1'b0));
        @(negedge clk);
        set_m(1, 0, 0, 0, '0, '0, 3'b000);
        @(negedge clk);
`endif

        // Randomized run against the reference model
        @(negedge clk);
        rst = 1'b1;
        m_mode = 0; m_own = 0; m_last = 1; m_cnt = 0;
        c0 = 1'b0; c1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) c0 = ~c0;
            if ($urandom_range(3) == 0) c1 = ~c1;
            set_m(0, c0, ($urandom_range(3) != 0), 1'($urandom), AW'($urandom), $urandom, 3'($urandom));
            set_m(1, c1, ($urandom_range(3) != 0), 1'($urandom), AW'($urandom), $urandom, 3'($urandom));
            bus.m0_sel_i = 4'($urandom);
            bus.m1_sel_i = 4'($urandom);
            bus.wb_ack_i = ($urandom_range(2) == 0);
            bus.wb_dat_i = $urandom;
            #1;
            exp_m = TOEN && (m_mode == 1) && (m_cnt == TO);
            e = expect_for((m_mode == 1) ? m_own : -1, (m_mode == 1) && !exp_m && bus.wb_ack_i, exp_m);
            check_obs($sformatf("random[%0d]", n), e);
            model_step(exp_m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sdram_wb_arb.md
SDRAM_WB_ARB -- requirements
Module: sdram_wb_arb

Interface
REQ-001 Parameter: dw, default 32, Wishbone data width.
REQ-002 Parameter: aw, default 26, Wishbone address width.
REQ-003 Parameter: TIMEOUT, default 255, maximum wait cycles for ack (used only with SDRAM_WB_ARB_TIMEOUT_EN).
REQ-004 Port: sys_clk  in  1  single clock for the whole block.
REQ-005 Port: RESET  in  1  asynchronous reset, active-high.
REQ-006 Ports: mN_cyc_i, mN_stb_i, mN_we_i  in  1 each  Wishbone controls from master N (N=0,1).
REQ-007 Ports: mN_addr_i  in  aw; mN_dat_i  in  dw; mN_sel_i  in  dw/8; mN_cti_i  in  3  master N request fields.
REQ-008 Ports: mN_ack_o  out  1; mN_err_o  out  1; mN_dat_o  out  dw  master N responses.
REQ-009 Ports: wb_cyc_o, wb_stb_o, wb_we_o  out  1 each; wb_addr_o  out  aw; wb_dat_o  out  dw; wb_sel_o  out  dw/8; wb_cti_o  out  3  toward the SDRAM controller Wishbone slave.
REQ-010 Ports: wb_ack_i  in  1; wb_dat_i  in  dw  from the SDRAM controller.
REQ-011 Port: grant_o  out  2  one-hot current owner (00 = none).

Function
REQ-012 Request of master N SHALL be req_N = mN_cyc_i & mN_stb_i.
REQ-013 FSM states SHALL be IDLE, OWN0, OWN1, ABORT; state registered on sys_clk.
REQ-014 IDLE: single requester -> its OWN state; both requesting -> master not served last (rr pointer); none -> stay.
REQ-015 OWNn: stay while mN_cyc_i=1 (bus locked across bursts, cti ignored for arbitration).
REQ-016 OWNn with mN_cyc_i=0: other master requesting -> OWN(other); else same master requesting -> OWNn; else IDLE.
REQ-017 rr pointer SHALL update to n on every entry into OWNn.
REQ-018 Arbitration latency: request seen in IDLE -> wb_stb_o asserted on next cycle, never same cycle.
REQ-019 In OWNn, all wb_*_o SHALL equal master n fields combinationally; in IDLE/ABORT wb_cyc_o=wb_stb_o=wb_we_o=0, other wb_*_o=0.
REQ-020 mN_ack_o = wb_ack_i only when state is OWNn; non-owner ack SHALL be 0.
REQ-021 mN_dat_o SHALL be wb_dat_i broadcast to both masters (qualified by ack).
REQ-022 grant_o SHALL be 01 in OWN0, 10 in OWN1, 00 otherwise.
REQ-023 wb_ack_i arriving while state is IDLE/ABORT SHALL be dropped.

Reset
REQ-024 RESET=1 SHALL force state IDLE, rr pointer to "last=1" (m0 wins first tie), timeout counter 0, all outputs 0, asynchronously.
REQ-025 RESET mid-transfer SHALL drop wb_cyc_o immediately; no ack/err propagated; masters restart their cycle.

Configuration
REQ-026 Macro SDRAM_WB_ARB_TIMEOUT_EN defined: counter cleared on entry to OWNn and on each wb_ack_i, increments each OWNn cycle with wb_stb_o=1 and wb_ack_i=0.
REQ-027 Counter reaching TIMEOUT: mN_err_o=1 for exactly one cycle to owner, state -> ABORT.
REQ-028 ABORT: hold slave bus idle until aborted master drops cyc, then apply IDLE rules next cycle.
REQ-029 Macro undefined: no counter, ABORT unreachable, mN_err_o tied 0, ports unchanged.

Structure
REQ-030 Package sdram_wb_arb_pkg SHALL hold the state enum, grant encodings and default TIMEOUT constant.
REQ-031 Sub-module sdram_wb_arb_wdt SHALL implement the timeout counter (clear, count, expire), instantiated only under SDRAM_WB_ARB_TIMEOUT_EN.

Verification
REQ-032 m0 write addr 0x010 data 0xDEADBEEF alone -> grant_o=01 one cycle after req, wb_addr_o=0x010, m0_ack_o pulses, m1_ack_o stays 0.
REQ-033 m0 and m1 request same cycle from reset -> m0 served first; after m0 cyc drops, grant_o goes 01->10 directly, no IDLE cycle.
REQ-034 m1 holds cyc across 4-beat burst (cti=010, last 111) while m0 requests -> m0 waits until m1 cyc=0; four acks to m1 only.
REQ-035 Read by m1 addr 0x020 after m0 writes 0x12345678 there -> m1_dat_o=0x12345678 with m1_ack_o=1.
REQ-036 RESET pulsed during m0 OWN0 -> wb_cyc_o=0 and grant_o=00 same cycle, FSM IDLE after release.
REQ-037 With SDRAM_WB_ARB_TIMEOUT_EN, TIMEOUT=8, slave never acks -> m0_err_o one-cycle pulse after 8 stb cycles, ABORT until m0 cyc=0, pending m1 then granted.
